// File: rtl/mul_sequencer_pkg.sv
// Shared types and constants for the multiply sequencer slice.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
//
// Contents: operand/result widths, default queue depth, FSM state encoding,
// and the packed operand-pair type stored in the queue.
package mul_sequencer_pkg;

  localparam int OP_W          = 8;
  localparam int RES_W         = 16;
  localparam int DEFAULT_DEPTH = 4;

  // Sequencer FSM encoding.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_WAIT = 2'd2,
    ST_HOLD = 2'd3
  } state_t;

  // One queued multiply request.
  typedef struct packed {
    logic [OP_W-1:0] a;
    logic [OP_W-1:0] b;
  } pair_t;

endpackage : mul_sequencer_pkg

// File: rtl/mul_sequencer_if.sv
// Bundle of every non-clock signal of the multiply sequencer.
// Latency: n/a (wires only).
// Backpressure: in_ready / out_ready valid-ready handshakes carried through.
//
// Signals:
//   in_valid/in_a/in_b/in_ready   operand-pair input handshake
//   out_valid/out_data/out_ready  product output handshake
//   mul_reset/mul_a/mul_b         load controls toward the external multiplier
//   mul_ready/mul_out             done flag and product from the multiplier
//   busy                          sequencer has work queued or in flight
// Modports: slave = sequencer side, master = environment side.
interface mul_sequencer_if;
  import mul_sequencer_pkg::*;

  logic             in_valid;
  logic [OP_W-1:0]  in_a;
  logic [OP_W-1:0]  in_b;
  logic             in_ready;

  logic             out_valid;
  logic [RES_W-1:0] out_data;
  logic             out_ready;

  logic             mul_reset;
  logic [OP_W-1:0]  mul_a;
  logic [OP_W-1:0]  mul_b;
  logic             mul_ready;
  logic [RES_W-1:0] mul_out;

  logic             busy;

  modport slave (
    input  in_valid, in_a, in_b, out_ready, mul_ready, mul_out,
    output in_ready, out_valid, out_data, mul_reset, mul_a, mul_b, busy
  );

  modport master (
    output in_valid, in_a, in_b, out_ready, mul_ready, mul_out,
    input  in_ready, out_valid, out_data, mul_reset, mul_a, mul_b, busy
  );

endinterface : mul_sequencer_if

// File: rtl/mul_sequencer_fifo.sv
// seq_fifo: synchronous FIFO of operand pairs for the multiply sequencer.
// Latency: a pushed entry is visible at pop_dat the cycle after the push edge.
// Backpressure: pushes while full and pops while empty are ignored.
//
// Ports:
//   clk, reset          clock, synchronous active-high reset (empties the queue)
//   push, push_dat      write request and data
//   pop, pop_dat        read request; pop_dat shows the head entry combinationally
//   full, empty, count  occupancy status
// DEPTH must be a power of two so the pointers wrap by simple overflow.
module seq_fifo
  import mul_sequencer_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  pair_t                      push_dat,
  input  logic                       pop,
  output pair_t                      pop_dat,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  pair_t              mem_q [DEPTH];
  pair_t              mem_d [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;

  logic do_push;
  logic do_pop;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign pop_dat = mem_q[rd_ptr_q];

  // Guard the requests so a stray push/pop can never corrupt the pointers.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;

    if (do_push) begin
      mem_d[wr_ptr_q] = push_dat;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end

    // Simultaneous push and pop leaves the occupancy unchanged.
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: entries are only read once count says they are valid.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule : seq_fifo

// File: rtl/mul_sequencer.sv
// Queues operand pairs and feeds them one at a time to an external shift-add multiplier.
// Latency: accept to out_valid is 4 + bitlen(b) cycles when idle with an empty queue.
// Backpressure: in_ready = queue not full; a product is held in out_data until out_ready.
//
// Ports:
//   clk    clock, all state changes on the rising edge
//   reset  synchronous active-high; flushes queue and in-flight work
//   sif    mul_sequencer_if.slave: input/output handshakes, multiplier
//          load/result signals and busy
//
// Flow: IDLE pops the queue head into mul_a/mul_b, LOAD pulses mul_reset so the
// multiplier latches them, WAIT watches mul_ready, HOLD presents the product
// until it is taken. Only one pair is ever inside the multiplier.
module mul_sequencer
  import mul_sequencer_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic             clk,
  input  logic             reset,
  mul_sequencer_if.slave   sif
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  state_t            state_q, state_d;
  logic [OP_W-1:0]   mul_a_q, mul_a_d;
  logic [OP_W-1:0]   mul_b_q, mul_b_d;
  logic              out_valid_q, out_valid_d;
  logic [RES_W-1:0]  out_data_q, out_data_d;

  logic              fifo_push;
  logic              fifo_pop;
  pair_t             fifo_in;
  pair_t             fifo_head;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CNT_W-1:0]  fifo_count;

  // ---------------------------------------------------------------------------
  // Operand queue
  // ---------------------------------------------------------------------------
  assign fifo_in.a = sif.in_a;
  assign fifo_in.b = sif.in_b;
  assign fifo_push = sif.in_valid && !fifo_full;

  seq_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (fifo_push),
    .push_dat (fifo_in),
    .pop      (fifo_pop),
    .pop_dat  (fifo_head),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

  // ---------------------------------------------------------------------------
  // Sequencer FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    mul_a_d     = mul_a_q;
    mul_b_d     = mul_b_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    fifo_pop    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          mul_a_d  = fifo_head.a;
          mul_b_d  = fifo_head.b;
          state_d  = ST_LOAD;
        end
      end

      // mul_reset is high in this state, so the multiplier latches mul_a/mul_b
      // and clears its done flag on the way out.
      ST_LOAD: begin
        state_d = ST_WAIT;
      end

      ST_WAIT: begin
        if (sif.mul_ready) begin
          out_data_d  = sif.mul_out;
          out_valid_d = 1'b1;
          state_d     = ST_HOLD;
        end
      end

      // The next pair is popped on the same edge the product is taken, which
      // saves the IDLE cycle when work is already queued.
      ST_HOLD: begin
        if (sif.out_ready) begin
          out_valid_d = 1'b0;
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            mul_a_d  = fifo_head.a;
            mul_b_d  = fifo_head.b;
            state_d  = ST_LOAD;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      mul_a_q     <= '0;
      mul_b_q     <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      mul_a_q     <= mul_a_d;
      mul_b_q     <= mul_b_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign sif.in_ready  = !fifo_full;
  assign sif.out_valid = out_valid_q;
  assign sif.out_data  = out_data_q;
  assign sif.mul_a     = mul_a_q;
  assign sif.mul_b     = mul_b_q;

  // Reset is ORed in so the multiplier reloads (with zeros once the operand
  // registers clear) and drops any product it was computing.
  assign sif.mul_reset = reset || (state_q == ST_LOAD);

  assign sif.busy      = (state_q != ST_IDLE) || (fifo_count != '0);

endmodule : mul_sequencer

// File: tb/tb_mul_sequencer.sv
// Testbench for mul_sequencer paired with a shift-add multiplier model.
// Latency: n/a.
// Backpressure: drives in_valid/out_ready patterns including long output stalls.
module tb_mul_sequencer;

  logic clk;
  logic reset;

  mul_sequencer_if sif ();

  mul_sequencer #(
    .DEPTH (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .sif   (sif)
  );

  int checks = 0;
  int fails  = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // 16-bit-result shift-add multiplier: mul_reset loads the operands and clears
  // the done flag; one multiplier bit is consumed per cycle; ready rises the
  // cycle after the multiplier operand reaches zero.
  logic [15:0] m_acc;
  logic [15:0] m_a;
  logic [7:0]  m_b;
  logic        m_rdy;

  always_ff @(posedge clk) begin
    if (sif.mul_reset) begin
      m_acc <= 16'd0;
      m_a   <= {8'd0, sif.mul_a};
      m_b   <= sif.mul_b;
      m_rdy <= 1'b0;
    end else if (m_b == 8'd0) begin
      m_rdy <= 1'b1;
    end else begin
      if (m_b[0]) m_acc <= m_acc + m_a;
      m_a <= m_a << 1;
      m_b <= m_b >> 1;
    end
  end

  assign sif.mul_ready = m_rdy;
  assign sif.mul_out   = m_acc;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset         = 1'b1;
    sif.in_valid  = 1'b0;
    sif.in_a      = 8'd0;
    sif.in_b      = 8'd0;
    sif.out_ready = 1'b0;
    #1;
    checks++;
    if (sif.mul_reset !== 1'b1) begin
      fails++; $display("FAIL reset_mul_reset: got %b want 1", sif.mul_reset);
    end
    tick;
    tick;
    checks++;
    if (sif.out_valid !== 1'b0) begin
      fails++; $display("FAIL reset_out_valid: got %b want 0", sif.out_valid);
    end
    checks++;
    if (sif.out_data !== 16'd0) begin
      fails++; $display("FAIL reset_out_data: got %0d want 0", sif.out_data);
    end
    checks++;
    if (sif.mul_a !== 8'd0 || sif.mul_b !== 8'd0) begin
      fails++; $display("FAIL reset_mul_ab: got %0d/%0d want 0/0", sif.mul_a, sif.mul_b);
    end
    checks++;
    if (sif.in_ready !== 1'b1) begin
      fails++; $display("FAIL reset_in_ready: got %b want 1", sif.in_ready);
    end
    checks++;
    if (sif.busy !== 1'b0) begin
      fails++; $display("FAIL reset_busy: got %b want 0", sif.busy);
    end
    reset = 1'b0;
    tick;
  endtask

  // Single operations from idle with out_ready held high: value and latency.
  task automatic test_latency;
    logic [7:0]  va [4];
    logic [7:0]  vb [4];
    logic [15:0] vp [4];
    int          vl [4];
    va = '{8'd3,  8'd200, 8'd255,    8'd1};
    vb = '{8'd5,  8'd0,   8'd255,    8'd128};
    vp = '{16'd15, 16'd0, 16'd65025, 16'd128};
    vl = '{7, 4, 12, 12};
    sif.out_ready = 1'b1;
    for (int v = 0; v < 4; v++) begin
      int n;
      bit seen;
      sif.in_valid = 1'b1;
      sif.in_a     = va[v];
      sif.in_b     = vb[v];
      checks++;
      if (sif.in_ready !== 1'b1) begin
        fails++; $display("FAIL lat_in_ready[%0d]: got %b want 1", v, sif.in_ready);
      end
      tick;
      sif.in_valid = 1'b0;
      n    = 0;
      seen = 1'b0;
      while (!seen && n < 40) begin
        tick;
        n++;
        if (n == 1) begin
          checks++;
          if (sif.mul_a !== va[v] || sif.mul_b !== vb[v] || sif.mul_reset !== 1'b1) begin
            fails++;
            $display("FAIL lat_load[%0d]: got a=%0d b=%0d mul_reset=%b want a=%0d b=%0d mul_reset=1",
                     v, sif.mul_a, sif.mul_b, sif.mul_reset, va[v], vb[v]);
          end
        end
        if (sif.out_valid === 1'b1) seen = 1'b1;
      end
      checks++;
      if (!seen || n != vl[v]) begin
        fails++; $display("FAIL lat_cycles[%0d]: got %0d (seen=%b) want %0d", v, n, seen, vl[v]);
      end
      checks++;
      if (sif.out_data !== vp[v]) begin
        fails++; $display("FAIL lat_product[%0d]: got %0d want %0d", v, sif.out_data, vp[v]);
      end
      tick;
      checks++;
      if (sif.out_valid !== 1'b0 || sif.busy !== 1'b0) begin
        fails++; $display("FAIL lat_drain[%0d]: got out_valid=%b busy=%b want 0/0",
                          v, sif.out_valid, sif.busy);
      end
      tick;
    end
    sif.out_ready = 1'b0;
  endtask

  // Three pairs pushed consecutively; each product held until taken.
  task automatic test_back_to_back;
    logic [7:0]  pa [3];
    logic [7:0]  pb [3];
    logic [15:0] pe [3];
    pa = '{8'd1, 8'd2, 8'd4};
    pb = '{8'd1, 8'd3, 8'd0};
    pe = '{16'd1, 16'd6, 16'd0};
    sif.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      sif.in_valid = 1'b1;
      sif.in_a     = pa[i];
      sif.in_b     = pb[i];
      checks++;
      if (sif.in_ready !== 1'b1) begin
        fails++; $display("FAIL b2b_in_ready[%0d]: got %b want 1", i, sif.in_ready);
      end
      tick;
    end
    sif.in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      int n;
      n = 0;
      while (sif.out_valid !== 1'b1 && n < 40) begin
        tick;
        n++;
      end
      checks++;
      if (sif.out_valid !== 1'b1 || sif.out_data !== pe[i]) begin
        fails++; $display("FAIL b2b_result[%0d]: got valid=%b data=%0d want valid=1 data=%0d",
                          i, sif.out_valid, sif.out_data, pe[i]);
      end
      repeat (3) tick;
      checks++;
      if (sif.out_valid !== 1'b1 || sif.out_data !== pe[i]) begin
        fails++; $display("FAIL b2b_hold[%0d]: got valid=%b data=%0d want valid=1 data=%0d",
                          i, sif.out_valid, sif.out_data, pe[i]);
      end
      sif.out_ready = 1'b1;
      tick;
      sif.out_ready = 1'b0;
      checks++;
      if (sif.out_valid !== 1'b0) begin
        fails++; $display("FAIL b2b_taken[%0d]: got out_valid=%b want 0", i, sif.out_valid);
      end
    end
    checks++;
    if (sif.busy !== 1'b0) begin
      fails++; $display("FAIL b2b_idle: got busy=%b want 0", sif.busy);
    end
  endtask

  // Output stalled: DEPTH+1 pairs fit (one in the multiplier), then in_ready drops.
  task automatic test_stall;
    int          accepted;
    int          n;
    int          got;
    logic [15:0] se [5];
    se = '{16'd4, 16'd9, 16'd16, 16'd25, 16'd36};
    sif.out_ready = 1'b0;
    accepted = 0;
    for (int i = 0; i < 6; i++) begin
      sif.in_valid = 1'b1;
      sif.in_a     = 8'(i + 2);
      sif.in_b     = 8'(i + 2);
      if (sif.in_ready === 1'b1) accepted++;
      tick;
    end
    sif.in_valid = 1'b0;
    checks++;
    if (accepted != 5) begin
      fails++; $display("FAIL stall_accepted: got %0d want 5", accepted);
    end
    checks++;
    if (sif.in_ready !== 1'b0) begin
      fails++; $display("FAIL stall_in_ready: got %b want 0", sif.in_ready);
    end
    n = 0;
    while (sif.out_valid !== 1'b1 && n < 40) begin
      tick;
      n++;
    end
    repeat (20) tick;
    checks++;
    if (sif.out_valid !== 1'b1 || sif.out_data !== 16'd4 || sif.in_ready !== 1'b0) begin
      fails++; $display("FAIL stall_hold: got valid=%b data=%0d in_ready=%b want 1/4/0",
                        sif.out_valid, sif.out_data, sif.in_ready);
    end
    sif.out_ready = 1'b1;
    got = 0;
    n   = 0;
    while (got < 5 && n < 200) begin
      if (sif.out_valid === 1'b1) begin
        checks++;
        if (sif.out_data !== se[got]) begin
          fails++; $display("FAIL stall_drain[%0d]: got %0d want %0d", got, sif.out_data, se[got]);
        end
        got++;
      end
      tick;
      n++;
    end
    sif.out_ready = 1'b0;
    checks++;
    if (got != 5 || sif.busy !== 1'b0 || sif.in_ready !== 1'b1) begin
      fails++; $display("FAIL stall_end: got count=%0d busy=%b in_ready=%b want 5/0/1",
                        got, sif.busy, sif.in_ready);
    end
  endtask

  // Reset while a product is being computed and another pair is queued.
  task automatic test_reset_mid;
    int n;
    bit seen;
    sif.out_ready = 1'b1;
    sif.in_valid  = 1'b1;
    sif.in_a      = 8'd9;
    sif.in_b      = 8'd200;
    tick;
    sif.in_a      = 8'd10;
    sif.in_b      = 8'd10;
    tick;
    sif.in_valid  = 1'b0;
    tick;
    reset = 1'b1;
    #1;
    checks++;
    if (sif.mul_reset !== 1'b1) begin
      fails++; $display("FAIL rmid_mul_reset: got %b want 1", sif.mul_reset);
    end
    tick;
    checks++;
    if (sif.out_valid !== 1'b0 || sif.busy !== 1'b0 || sif.in_ready !== 1'b1) begin
      fails++; $display("FAIL rmid_state: got valid=%b busy=%b in_ready=%b want 0/0/1",
                        sif.out_valid, sif.busy, sif.in_ready);
    end
    tick;
    reset        = 1'b0;
    sif.in_valid = 1'b1;
    sif.in_a     = 8'd7;
    sif.in_b     = 8'd9;
    tick;
    sif.in_valid = 1'b0;
    n    = 0;
    seen = 1'b0;
    while (!seen && n < 40) begin
      tick;
      n++;
      if (sif.out_valid === 1'b1) seen = 1'b1;
    end
    checks++;
    if (!seen || n != 8 || sif.out_data !== 16'd63) begin
      fails++; $display("FAIL rmid_after: got data=%0d cycles=%0d seen=%b want data=63 cycles=8",
                        sif.out_data, n, seen);
    end
    tick;
    checks++;
    if (sif.out_valid !== 1'b0 || sif.busy !== 1'b0) begin
      fails++; $display("FAIL rmid_idle: got valid=%b busy=%b want 0/0", sif.out_valid, sif.busy);
    end
    sif.out_ready = 1'b0;
  endtask

  // 1000 random pairs, random input gaps and random out_ready; scoreboard order.
  task automatic test_random;
    logic [15:0] sb [$];
    int sent;
    int rcvd;
    int shown;
    sent  = 0;
    rcvd  = 0;
    shown = 0;
    sif.in_valid  = 1'b0;
    sif.out_ready = 1'b0;
    fork
      begin
        int dc;
        logic [7:0] ra;
        logic [7:0] rb;
        dc = 0;
        while (sent < 1000 && dc < 40000) begin
          if ($urandom_range(0, 3) != 0) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            sif.in_valid = 1'b1;
            sif.in_a     = ra;
            sif.in_b     = rb;
            while (sif.in_ready !== 1'b1 && dc < 40000) begin
              tick;
              dc++;
            end
            sb.push_back({8'd0, ra} * {8'd0, rb});
            sent++;
          end else begin
            sif.in_valid = 1'b0;
          end
          tick;
          dc++;
        end
        sif.in_valid = 1'b0;
      end
      begin
        int mc;
        logic [15:0] ev;
        mc = 0;
        while (rcvd < 1000 && mc < 40000) begin
          sif.out_ready = 1'($urandom_range(0, 1));
          if (sif.out_valid === 1'b1 && sif.out_ready === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
              fails++;
              if (shown < 10) $display("FAIL rand_extra[%0d]: got %0d want no output", rcvd, sif.out_data);
              shown++;
            end else begin
              ev = sb.pop_front();
              if (sif.out_data !== ev) begin
                fails++;
                if (shown < 10) $display("FAIL rand_product[%0d]: got %0d want %0d", rcvd, sif.out_data, ev);
                shown++;
              end
            end
            rcvd++;
          end
          tick;
          mc++;
        end
        sif.out_ready = 1'b0;
      end
    join
    checks++;
    if (sent != 1000 || rcvd != 1000) begin
      fails++; $display("FAIL rand_count: got sent=%0d received=%0d want 1000/1000", sent, rcvd);
    end
    checks++;
    if (sb.size() != 0) begin
      fails++; $display("FAIL rand_leftover: got %0d pending want 0", sb.size());
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_back_to_back();
    test_stall();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule : tb_mul_sequencer

// File: doc/mul_sequencer.md
MUL_SEQUENCER -- requirements
Module: mul_sequencer

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, setting the number of queued operand pairs (power of two, >=2).
REQ-002 The block SHALL have port clk  input  1  clock; all state changes on rising edge.
REQ-003 The block SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-004 The block SHALL have ports in_valid input 1, in_a input 8, in_b input 8, in_ready output 1, forming the operand-pair input handshake.
REQ-005 The block SHALL have ports out_valid output 1, out_data output 16, out_ready input 1, forming the product output handshake.
REQ-006 The block SHALL have ports mul_reset output 1, mul_a output 8, mul_b output 8 driving the downstream shift-add multiplier's load inputs.
REQ-007 The block SHALL have ports mul_ready input 1, mul_out input 16 receiving the multiplier's done flag and 16-bit product.
REQ-008 The block SHALL have port busy  output 1  high when FSM is not IDLE or the queue is non-empty.

Function
REQ-009 The input transfer SHALL occur on an edge where in_valid and in_ready are both 1; in_ready SHALL equal "queue not full", independent of in_valid.
REQ-010 Queue SHALL be FIFO, DEPTH entries of {a,b}; push and pop in the same cycle SHALL both take effect, count unchanged; pointers wrap modulo DEPTH.
REQ-011 FSM states SHALL be IDLE, LOAD, WAIT, HOLD.
REQ-012 IDLE: if queue non-empty, pop head into mul_a/mul_b registers, go LOAD; else stay.
REQ-013 LOAD: mul_reset SHALL be 1 for exactly this one cycle; next state WAIT.
REQ-014 WAIT: on mul_ready=1 capture mul_out into out_data, set out_valid=1, go HOLD; mul_ready in the first WAIT cycle is always 0 (cleared by the load).
REQ-015 HOLD: out_data and out_valid SHALL stay stable until out_ready=1; on that edge out_valid clears and, if queue non-empty, pop and go LOAD, else go IDLE.
REQ-016 mul_a/mul_b SHALL change only on a pop edge.
REQ-017 Latency from accept edge (empty queue, idle FSM) to out_valid=1 SHALL be 4 + bitlen(in_b) cycles (bitlen(0)=0).
REQ-018 out_data SHALL equal in_a*in_b exactly (16-bit, no overflow possible); results SHALL emerge in acceptance order.
REQ-019 At most one pair is in the multiplier at a time; DEPTH+1 pairs SHALL be acceptable before in_ready drops while output is stalled.

Reset
REQ-020 While reset=1: queue emptied, FSM->IDLE, out_valid=0, out_data=0, mul_a=0, mul_b=0, in_ready=1 on the following cycle, busy=0.
REQ-021 mul_reset SHALL be 1 whenever reset=1, so the multiplier is reloaded with zeros.
REQ-022 Reset in any state, including mid-WAIT or HOLD, SHALL discard in-flight and queued pairs; no product SHALL be emitted for them.

Structure
REQ-023 Shared package SHALL hold OP_W=8, RES_W=16, DEFAULT_DEPTH=4 and the FSM state encoding.
REQ-024 The queue SHALL be a sub-module seq_fifo (push/pop/full/empty/count); the FSM and handshake logic live in mul_sequencer.
REQ-025 The multiplier SHALL NOT be instantiated inside; it connects externally via the mul_* ports.

Verification
REQ-026 Bench SHALL pair the DUT with the existing 16-bit-result shift-add multiplier model.
REQ-027 Single op a=3,b=5, out_ready=1 -> out_data=15, out_valid rises 7 cycles after accept.
REQ-028 a=200,b=0 -> out_data=0 after 4 cycles; a=255,b=255 -> out_data=65025 after 12 cycles.
REQ-029 Back-to-back pairs (1,1),(2,3),(4,0) -> outputs 1,6,0 in order, each held until out_ready.
REQ-030 out_ready=0, push 6 pairs back-to-back -> exactly 5 accepted, then in_ready=0; out_data stays at first product.
REQ-031 Reset asserted during WAIT -> next cycle out_valid=0, busy=0, in_ready=1, mul_reset=1 during reset; subsequent pair (7,9) -> 63.
REQ-032 Randomised 1000 pairs with random out_ready -> every product correct, order preserved, no loss or duplication.
